// File: rtl/vga_checkboard_cursor_gen_pkg.sv
// Shared colour definitions and encodings for the checkerboard/cursor generator.
// Colours are 3-bit {R,G,B}; the select code picks which colour the pixel mux emits.
package vga_checkboard_cursor_gen_pkg;

  localparam int COLOR_WIDTH = 3;

  localparam logic [COLOR_WIDTH-1:0] COLOR_BLACK = 3'b000;
  localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 3'b111;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 3'b100;

  typedef enum logic [1:0] {
    SEL_A    = 2'b00,
    SEL_B    = 2'b01,
    SEL_MARK = 2'b10,
    SEL_BG   = 2'b11
  } colorSel_e;

  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } blinkPhase_e;

endpackage

// File: rtl/vga_checkboard_cursor_gen_if.sv
// Bundle of move buttons, video timing inputs and the cursor/colour outputs.
// The master side is the surrounding system; the slave side is the generator.
interface vga_checkboard_cursor_gen_if
  import vga_checkboard_cursor_gen_pkg::*;
#(
  parameter int X_WIDTH   = 8,
  parameter int Y_WIDTH   = 8,
  parameter int POS_WIDTH = 3
);

  logic                   iMoveUp;
  logic                   iMoveDown;
  logic                   iMoveLeft;
  logic                   iMoveRight;
  logic                   iBlinkEnable;
  logic [X_WIDTH-1:0]     iVideoCol;
  logic [Y_WIDTH-1:0]     iVideoRow;
  logic                   iDisplay;
  logic [POS_WIDTH-1:0]   oMarkedBlockPosX;
  logic [POS_WIDTH-1:0]   oMarkedBlockPosY;
  logic [COLOR_WIDTH-1:0] oVGAColor;

  modport master (
    output iMoveUp, iMoveDown, iMoveLeft, iMoveRight, iBlinkEnable,
    output iVideoCol, iVideoRow, iDisplay,
    input  oMarkedBlockPosX, oMarkedBlockPosY, oVGAColor
  );

  modport slave (
    input  iMoveUp, iMoveDown, iMoveLeft, iMoveRight, iBlinkEnable,
    input  iVideoCol, iVideoRow, iDisplay,
    output oMarkedBlockPosX, oMarkedBlockPosY, oVGAColor
  );

endinterface

// File: rtl/vga_cursor_ctrl.sv
// Cursor position and blink control: button edge detection, wrap-around
// cursor registers and the blink half-period counter/phase.
module vga_cursor_ctrl
  import vga_checkboard_cursor_gen_pkg::*;
#(
  parameter int BLOCKS_X          = 4,
  parameter int BLOCKS_Y          = 4,
  parameter int POS_WIDTH         = 3,
  parameter int BLINK_HALF_PERIOD = 25000000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 moveUp,
  input  logic                 moveDown,
  input  logic                 moveLeft,
  input  logic                 moveRight,
  input  logic                 blinkEnable,
  output logic [POS_WIDTH-1:0] posX,
  output logic [POS_WIDTH-1:0] posY,
  output logic                 blinkVisible
);

  localparam int CNT_WIDTH = (BLINK_HALF_PERIOD > 2) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BLINK_HALF_PERIOD - 1);
  localparam logic [POS_WIDTH-1:0] X_LAST   = POS_WIDTH'(BLOCKS_X - 1);
  localparam logic [POS_WIDTH-1:0] Y_LAST   = POS_WIDTH'(BLOCKS_Y - 1);

  logic [3:0]           moveNow;
  logic [3:0]           moveHist;
  logic [3:0]           movePulse;
  logic [POS_WIDTH-1:0] nextX;
  logic [POS_WIDTH-1:0] nextY;
  logic [CNT_WIDTH-1:0] blinkCount;
  logic [CNT_WIDTH-1:0] nextCount;
  blinkPhase_e          phase;
  blinkPhase_e          nextPhase;

  // Bit order {up, down, left, right}; history starts at 0 so a button held
  // through reset still yields exactly one move afterwards.
  assign moveNow   = {moveUp, moveDown, moveLeft, moveRight};
  assign movePulse = moveNow & ~moveHist;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      moveHist   <= '0;
      posX       <= '0;
      posY       <= '0;
      blinkCount <= '0;
      phase      <= PHASE_VISIBLE;
    end else begin
      moveHist   <= moveNow;
      posX       <= nextX;
      posY       <= nextY;
      blinkCount <= nextCount;
      phase      <= nextPhase;
    end
  end

  // Opposing pulses cancel; horizontal and vertical moves are independent.
  always_comb begin
    nextX = posX;
    nextY = posY;
    if (movePulse[0] && !movePulse[1])
      nextX = (posX == X_LAST) ? '0 : posX + 1'b1;
    else if (movePulse[1] && !movePulse[0])
      nextX = (posX == '0) ? X_LAST : posX - 1'b1;
    if (movePulse[2] && !movePulse[3])
      nextY = (posY == Y_LAST) ? '0 : posY + 1'b1;
    else if (movePulse[3] && !movePulse[2])
      nextY = (posY == '0) ? Y_LAST : posY - 1'b1;
  end

  always_comb begin
    nextCount = blinkCount;
    nextPhase = phase;
    if (!blinkEnable) begin
      nextCount = '0;
      nextPhase = PHASE_VISIBLE;
    end else if (blinkCount == CNT_LAST) begin
      nextCount = '0;
      nextPhase = (phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
    end else begin
      nextCount = blinkCount + 1'b1;
    end
  end

  // Disabling blink shows the mark immediately rather than after the phase register catches up.
  assign blinkVisible = (phase == PHASE_VISIBLE) || !blinkEnable;

endmodule

// File: rtl/vga_checkboard_cursor_gen.sv
// Checkerboard pixel generator with a movable, optionally blinking marked block.
// Colour is registered: pixel inputs at cycle N appear on oVGAColor at N+1.
module vga_checkboard_cursor_gen
  import vga_checkboard_cursor_gen_pkg::*;
#(
  parameter int X_WIDTH           = 8,
  parameter int Y_WIDTH           = 8,
  parameter int BLOCK_SHIFT_X     = 6,
  parameter int BLOCK_SHIFT_Y     = 6,
  parameter int BLOCKS_X          = 4,
  parameter int BLOCKS_Y          = 4,
  parameter int POS_WIDTH         = 3,
  parameter int BLINK_HALF_PERIOD = 25000000,
  parameter logic [COLOR_WIDTH-1:0] COLOR_A    = COLOR_BLACK,
  parameter logic [COLOR_WIDTH-1:0] COLOR_B    = COLOR_WHITE,
  parameter logic [COLOR_WIDTH-1:0] COLOR_MARK = COLOR_RED,
  parameter logic [COLOR_WIDTH-1:0] COLOR_BG   = COLOR_BLACK
) (
  input logic                         Clock,
  input logic                         Reset,
  vga_checkboard_cursor_gen_if.slave  bus
);

  logic [POS_WIDTH-1:0]   posX;
  logic [POS_WIDTH-1:0]   posY;
  logic                   blinkVisible;
  logic [X_WIDTH-1:0]     bx;
  logic [Y_WIDTH-1:0]     by;
  logic                   outOfGrid;
  logic                   onCursor;
  colorSel_e              colorSel;
  logic [COLOR_WIDTH-1:0] pixelColor;

  vga_cursor_ctrl #(
    .BLOCKS_X          (BLOCKS_X),
    .BLOCKS_Y          (BLOCKS_Y),
    .POS_WIDTH         (POS_WIDTH),
    .BLINK_HALF_PERIOD (BLINK_HALF_PERIOD)
  ) cursorCtrl (
    .Clock        (Clock),
    .Reset        (Reset),
    .moveUp       (bus.iMoveUp),
    .moveDown     (bus.iMoveDown),
    .moveLeft     (bus.iMoveLeft),
    .moveRight    (bus.iMoveRight),
    .blinkEnable  (bus.iBlinkEnable),
    .posX         (posX),
    .posY         (posY),
    .blinkVisible (blinkVisible)
  );

  assign bus.oMarkedBlockPosX = posX;
  assign bus.oMarkedBlockPosY = posY;

  // Block indices keep full width so columns beyond the grid compare as out-of-range.
  assign bx        = bus.iVideoCol >> BLOCK_SHIFT_X;
  assign by        = bus.iVideoRow >> BLOCK_SHIFT_Y;
  assign outOfGrid = (32'(bx) >= BLOCKS_X) || (32'(by) >= BLOCKS_Y);
  assign onCursor  = (32'(bx) == 32'(posX)) && (32'(by) == 32'(posY));

  always_comb begin
    colorSel = SEL_BG;
    if (!bus.iDisplay || outOfGrid)
      colorSel = SEL_BG;
    else if (onCursor && blinkVisible)
      colorSel = SEL_MARK;
    else if (bx[0] ^ by[0])
      colorSel = SEL_B;
    else
      colorSel = SEL_A;
  end

  always_comb begin
    pixelColor = COLOR_BG;
    case (colorSel)
      SEL_A:    pixelColor = COLOR_A;
      SEL_B:    pixelColor = COLOR_B;
      SEL_MARK: pixelColor = COLOR_MARK;
      SEL_BG:   pixelColor = COLOR_BG;
      default:  pixelColor = COLOR_BG;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      bus.oVGAColor <= COLOR_BG;
    else
      bus.oVGAColor <= pixelColor;
  end

endmodule

// File: tb/tb_vga_checkboard_cursor_gen.sv
// Directed bench for the checkerboard/cursor generator; colours are distinct so
// every select outcome is observable.
module tb_vga_checkboard_cursor_gen;

  localparam logic [2:0] C_A    = 3'b010;
  localparam logic [2:0] C_B    = 3'b111;
  localparam logic [2:0] C_MARK = 3'b100;
  localparam logic [2:0] C_BG   = 3'b001;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 Clock = ~Clock;

  vga_checkboard_cursor_gen_if #(.X_WIDTH(8), .Y_WIDTH(8), .POS_WIDTH(3)) bus ();
  vga_checkboard_cursor_gen_if #(.X_WIDTH(8), .Y_WIDTH(8), .POS_WIDTH(3)) bus2 ();

  vga_checkboard_cursor_gen #(
    .BLINK_HALF_PERIOD (4),
    .COLOR_A (C_A), .COLOR_B (C_B), .COLOR_MARK (C_MARK), .COLOR_BG (C_BG)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Narrower grid instance used only for the out-of-grid column check.
  vga_checkboard_cursor_gen #(
    .BLOCKS_X (3),
    .BLINK_HALF_PERIOD (4),
    .COLOR_A (C_A), .COLOR_B (C_B), .COLOR_MARK (C_MARK), .COLOR_BG (C_BG)
  ) dut2 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus2)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic display, input logic [7:0] col, input logic [7:0] row);
    bus.iDisplay  = display;
    bus.iVideoCol = col;
    bus.iVideoRow = row;
  endtask

  // Drive one move input high for a cycle, then low for a cycle.
  task automatic pulseMove(input int which);
    case (which)
      0: bus.iMoveUp    = 1'b1;
      1: bus.iMoveDown  = 1'b1;
      2: bus.iMoveLeft  = 1'b1;
      default: bus.iMoveRight = 1'b1;
    endcase
    tick();
    bus.iMoveUp = 1'b0; bus.iMoveDown = 1'b0; bus.iMoveLeft = 1'b0; bus.iMoveRight = 1'b0;
    tick();
  endtask

  initial begin
    logic [2:0] expX [4];
    expX[0] = 3'd1; expX[1] = 3'd2; expX[2] = 3'd3; expX[3] = 3'd0;

    bus.iMoveUp = 1'b0; bus.iMoveDown = 1'b0; bus.iMoveLeft = 1'b0; bus.iMoveRight = 1'b0;
    bus.iBlinkEnable = 1'b0;
    bus2.iMoveUp = 1'b0; bus2.iMoveDown = 1'b0; bus2.iMoveLeft = 1'b0; bus2.iMoveRight = 1'b0;
    bus2.iBlinkEnable = 1'b0;
    bus2.iDisplay = 1'b1; bus2.iVideoCol = 8'd0; bus2.iVideoRow = 8'd0;
    applyStimulus(1'b1, 8'd70, 8'd10);

    tick();
    tick();
    checkOutput("resetColor", 8'(bus.oVGAColor), 8'(C_BG));
    checkOutput("resetPosX", 8'(bus.oMarkedBlockPosX), 8'd0);
    checkOutput("resetPosY", 8'(bus.oMarkedBlockPosY), 8'd0);

    Reset = 1'b0;
    tick();
    checkOutput("pix70_10", 8'(bus.oVGAColor), 8'(C_B));
    applyStimulus(1'b1, 8'd130, 8'd70);
    tick();
    checkOutput("pix130_70", 8'(bus.oVGAColor), 8'(C_B));
    applyStimulus(1'b1, 8'd0, 8'd0);
    tick();
    checkOutput("pixCursor00", 8'(bus.oVGAColor), 8'(C_MARK));

    for (int i = 0; i < 4; i++) begin
      pulseMove(3);
      checkOutput("rightStep", 8'(bus.oMarkedBlockPosX), 8'(expX[i]));
    end
    pulseMove(0);
    checkOutput("upWrapY", 8'(bus.oMarkedBlockPosY), 8'd3);

    bus.iMoveDown = 1'b1;
    tick();
    checkOutput("holdDownFirst", 8'(bus.oMarkedBlockPosY), 8'd0);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("holdDownOnce", 8'(bus.oMarkedBlockPosY), 8'd0);
    bus.iMoveDown = 1'b0;
    tick();

    bus.iMoveLeft = 1'b1; bus.iMoveRight = 1'b1;
    tick();
    bus.iMoveLeft = 1'b0; bus.iMoveRight = 1'b0;
    tick();
    checkOutput("leftRightCancel", 8'(bus.oMarkedBlockPosX), 8'd0);

    pulseMove(3);
    pulseMove(1);
    bus.iMoveRight = 1'b1; bus.iMoveDown = 1'b1;
    tick();
    bus.iMoveRight = 1'b0; bus.iMoveDown = 1'b0;
    tick();
    checkOutput("diagX", 8'(bus.oMarkedBlockPosX), 8'd2);
    checkOutput("diagY", 8'(bus.oMarkedBlockPosY), 8'd2);
    applyStimulus(1'b1, 8'd128, 8'd128);
    tick();
    checkOutput("pixMark22", 8'(bus.oVGAColor), 8'(C_MARK));
    applyStimulus(1'b1, 8'd64, 8'd64);
    tick();
    checkOutput("pixA11", 8'(bus.oVGAColor), 8'(C_A));

    applyStimulus(1'b1, 8'd128, 8'd128);
    bus.iBlinkEnable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("blinkCycle", 8'(bus.oVGAColor), (i < 4) ? 8'(C_MARK) : 8'(C_A));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("blinkVisible2", 8'(bus.oVGAColor), 8'(C_MARK));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("blinkHidden2", 8'(bus.oVGAColor), 8'(C_A));
    end
    bus.iBlinkEnable = 1'b0;
    tick();
    checkOutput("blinkDisable", 8'(bus.oVGAColor), 8'(C_MARK));

    applyStimulus(1'b0, 8'd128, 8'd128);
    tick();
    checkOutput("displayOff", 8'(bus.oVGAColor), 8'(C_BG));

    bus2.iVideoCol = 8'd200; bus2.iVideoRow = 8'd10;
    tick();
    checkOutput("outOfGridX", 8'(bus2.oVGAColor), 8'(C_BG));
    bus2.iVideoCol = 8'd150;
    tick();
    checkOutput("inGridEdge", 8'(bus2.oVGAColor), 8'(C_A));

    pulseMove(1);
    checkOutput("moveTo23", 8'(bus.oMarkedBlockPosY), 8'd3);
    bus.iBlinkEnable = 1'b1;
    applyStimulus(1'b1, 8'd0, 8'd0);
    tick();
    tick();
    Reset = 1'b1;
    bus.iMoveRight = 1'b1;
    tick();
    checkOutput("midResetX", 8'(bus.oMarkedBlockPosX), 8'd0);
    checkOutput("midResetY", 8'(bus.oMarkedBlockPosY), 8'd0);
    checkOutput("midResetColor", 8'(bus.oVGAColor), 8'(C_BG));

    Reset = 1'b0;
    tick();
    checkOutput("heldThroughResetX", 8'(bus.oMarkedBlockPosX), 8'd1);
    checkOutput("postResetMark", 8'(bus.oVGAColor), 8'(C_MARK));
    tick();
    checkOutput("postResetMoved", 8'(bus.oVGAColor), 8'(C_A));
    checkOutput("heldNoRepeat", 8'(bus.oMarkedBlockPosX), 8'd1);
    bus.iMoveRight = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
